hw_trigger_unit: RTL
====================

# hw_trigger_unit

Parametrised hardware trigger unit: NUM_TRIG mcontrol-style address/PC triggers compared against the EX stage, with per-trigger match modes, arbitrary-length chaining, sticky hit flags, optional hit counting and registered debug-entry / breakpoint-exception requests. Sits beside the CSR file in the core; the debug CSR block supplies tdata1/2/3 per trigger and consumes the hit flags, and the pipeline control consumes the breakpoint requests.

## Interface
- NUM_TRIG, 4, number of triggers (1..8)
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 32, tdata register width
- cpu_clk  in  1  cpu clock
- cpu_rst  in  1  reset, asynchronous, active-high
- tdata1_all  in  NUM_TRIG*DATA_WIDTH  tdata1 per trigger, trigger i at [i*DATA_WIDTH +: DATA_WIDTH]
- tdata2_all  in  NUM_TRIG*DATA_WIDTH  compare value per trigger
- tdata3_all  in  NUM_TRIG*DATA_WIDTH  [15:0] hit count threshold per trigger
- tdata_wr  in  NUM_TRIG  one-cycle pulse: trigger i tdata1/2/3 written this cycle
- hit_clr  in  NUM_TRIG  one-cycle pulse: clear sticky hit i
- ex_valid  in  1  EX stage holds a valid, non-stalled instruction
- pc_ex  in  ADDR_WIDTH  PC at EX
- load_ex / store_ex  in  1 each  load / store at EX
- mem_addr_ex  in  ADDR_WIDTH  load/store address at EX
- dbg_mode  in  1  core in debug mode
- breakpoint  out  1  debug-entry request (action 1)
- breakpoint_exp  out  1  breakpoint-exception request (action 0)
- fire_id  out  3  index of firing trigger, valid with breakpoint/breakpoint_exp
- trig_hit  out  NUM_TRIG  sticky hit flags

## Operation
- Trigger i enabled when tdata1 type [DW-1:DW-4]==2 and m bit [6]=1; otherwise never matches. dmode [DW-5] must be 1 for action 1; action 1 with dmode 0 is treated as no action.
- Fields: action [15:12], chain [11], match [10:7], execute [2], store [1], load [0].
- Source: execute -> pc_ex; store -> mem_addr_ex when store_ex; load -> mem_addr_ex when load_ex. Multiple of {execute,store,load} set: any selected source matching counts.
- Match mode: 0 equal; 2 value >= tdata2; 3 value < tdata2; 1 NAPOT: compare ignoring bits [k:0] where k+1 = trailing ones of tdata2 (all-ones tdata2 matches everything). Other codes never match. Comparisons unsigned, ADDR_WIDTH bits, tdata2 truncated.
- Raw match qualified by ex_valid and !dbg_mode.
- Chaining: triggers i..j form a group when chain=1 on i..j-1 and chain=0 on j; group matches only if all members match in the same cycle; only j's action/count apply. chain on trigger NUM_TRIG-1 ignored.
- Fire: qualified group match (after count, see Configuration) with action 0 or 1. Several firings same cycle: lowest end index j wins; action 1 beats action 0 across all firings.
- trig_hit[j] set on every qualified group match of trigger j (independent of count); cleared by hit_clr[j] or tdata_wr[j]; set wins over clear same cycle.

## Timing
- Compare combinational on EX; breakpoint, breakpoint_exp, fire_id registered: EX match in cycle N -> outputs high for exactly cycle N+1 (one-cycle pulse per qualified match).
- Reset: breakpoint=0, breakpoint_exp=0, fire_id=0, trig_hit=0, all counters 0.
- dbg_mode high: no matches, counters hold, outputs 0 next cycle; a pulse registered in the cycle dbg_mode rises still appears.
- tdata_wr[i] in cycle N: trigger i does not fire for matches in cycle N; counter i cleared.
- Reset asserted mid-pulse clears outputs immediately.

## Configuration
- TRIG_HIT_COUNT_EN defined: per-trigger 16-bit counter; on qualified group match, if counter+1 >= tdata3[15:0] fire and clear counter, else increment and no fire. Threshold 0 or 1 fires every match.
- Undefined: no counters, tdata3_all ignored, every qualified group match fires.

## Test plan
- Trigger0 execute, equal, action1, dmode1, tdata2=0x100; pc_ex=0x100 ex_valid=1 cycle N -> breakpoint=1, fire_id=0 in N+1 only, trig_hit[0]=1 until hit_clr[0].
- Trigger1 load, match 2, tdata2=0x8000, action0; load at 0x7FFC then 0x8004 -> no pulse, then breakpoint_exp=1, fire_id=1.
- Chain t0(chain=1, execute pc=0x200) + t1(load 0x3000, action1): load at 0x3000 with pc 0x204 -> none; with pc 0x200 -> breakpoint, fire_id=1.
- NAPOT tdata2=0x10FF store trigger: stores to 0x1000, 0x10FF, 0x1100 -> fire, fire, none.
- TRIG_HIT_COUNT_EN, tdata3=3: five matches -> fire on 3rd only, counter=2 after 5th; tdata_wr clears counter to 0.
- dbg_mode=1 with matching pc and same-cycle t0 action0 / t2 action1 matches after exit -> no output while in debug; after exit breakpoint=1, fire_id=2, breakpoint_exp=0.

Source files
------------

// File: rtl/hw_trigger_unit.sv
// hw_trigger_unit: mcontrol-style address/PC triggers evaluated on the EX stage.
// Triggers can be chained into groups, keep sticky hit flags, and raise
// registered debug-entry / breakpoint-exception requests.
// Optional feature macro: TRIG_HIT_COUNT_EN enables a per-trigger hit counter
// so that a trigger fires only once every tdata3[15:0] qualified matches.
module hw_trigger_unit #(
    parameter int unsigned NUM_TRIG   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst,
    input  logic [NUM_TRIG*DATA_WIDTH-1:0] tdata1_all,
    input  logic [NUM_TRIG*DATA_WIDTH-1:0] tdata2_all,
    input  logic [NUM_TRIG*DATA_WIDTH-1:0] tdata3_all,
    input  logic [NUM_TRIG-1:0]            tdata_wr,
    input  logic [NUM_TRIG-1:0]            hit_clr,
    input  logic                           ex_valid,
    input  logic [ADDR_WIDTH-1:0]          pc_ex,
    input  logic                           load_ex,
    input  logic                           store_ex,
    input  logic [ADDR_WIDTH-1:0]          mem_addr_ex,
    input  logic                           dbg_mode,
    output logic                           breakpoint,
    output logic                           breakpoint_exp,
    output logic [2:0]                     fire_id,
    output logic [NUM_TRIG-1:0]            trig_hit
);

    localparam int unsigned CNT_WIDTH = 16;

    logic [NUM_TRIG-1:0] w_q;        // qualified per-trigger match
    logic [NUM_TRIG-1:0] w_chain;    // effective chain bit (last trigger never chains)
    logic [NUM_TRIG-1:0] w_act0;
    logic [NUM_TRIG-1:0] w_act1;
    logic [NUM_TRIG-1:0] w_grp;      // group match, flagged at the group end index
    logic [NUM_TRIG-1:0] w_cnt_ok;   // count threshold reached (always 1 without counters)
    logic [NUM_TRIG-1:0] w_fire;
    logic                w_run;
    logic                w_bp;
    logic                w_bpe;
    logic [2:0]          w_id;
    logic                w_unused;

    // Reserved tdata fields are intentionally ignored.
    assign w_unused = ^{tdata1_all, tdata2_all, tdata3_all};

    function automatic logic f_cmp(input logic [3:0]            mode,
                                   input logic [ADDR_WIDTH-1:0] val,
                                   input logic [ADDR_WIDTH-1:0] ref_val,
                                   input logic [ADDR_WIDTH-1:0] mask);
        case (mode)
            4'd0:    return val == ref_val;
            4'd1:    return (val & mask) == (ref_val & mask);
            4'd2:    return val >= ref_val;
            4'd3:    return val < ref_val;
            default: return 1'b0;
        endcase
    endfunction

`ifdef TRIG_HIT_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cnt [NUM_TRIG];
`endif

    for (genvar gi = 0; gi < int'(NUM_TRIG); gi++) begin : g_trig
        localparam int unsigned LB = gi * DATA_WIDTH;

        logic [ADDR_WIDTH-1:0] w_t2;
        logic [ADDR_WIDTH-1:0] w_mask;
        logic [3:0]            w_mode;
        logic                  w_en;
        logic                  w_raw;
        logic                  w_ones;

        assign w_t2   = tdata2_all[LB +: ADDR_WIDTH];
        assign w_mode = tdata1_all[LB+7 +: 4];
        assign w_en   = (tdata1_all[LB+DATA_WIDTH-1 -: 4] == 4'd2) && tdata1_all[LB+6];
        assign w_act0[gi] = (tdata1_all[LB+12 +: 4] == 4'd0);
        assign w_act1[gi] = (tdata1_all[LB+12 +: 4] == 4'd1) && tdata1_all[LB+DATA_WIDTH-5];

        if (gi == int'(NUM_TRIG) - 1) begin : g_last
            assign w_chain[gi] = 1'b0;
        end else begin : g_mid
            assign w_chain[gi] = tdata1_all[LB+11];
        end

        // NAPOT mask: clear every bit position covered by the trailing-ones run of tdata2
        always_comb begin
            w_mask = '1;
            w_ones = 1'b1;
            for (int b = 0; b < int'(ADDR_WIDTH); b++) begin
                w_ones    = w_ones & w_t2[b];
                w_mask[b] = ~w_ones;
            end
        end

        // Any selected source matching counts as a raw match
        assign w_raw = (tdata1_all[LB+2] && f_cmp(w_mode, pc_ex, w_t2, w_mask))
                     || (tdata1_all[LB+1] && store_ex && f_cmp(w_mode, mem_addr_ex, w_t2, w_mask))
                     || (tdata1_all[LB+0] && load_ex && f_cmp(w_mode, mem_addr_ex, w_t2, w_mask));

        assign w_q[gi] = w_en && w_raw && ex_valid && !dbg_mode;

`ifdef TRIG_HIT_COUNT_EN
        assign w_cnt_ok[gi] = ((17'(r_cnt[gi]) + 17'd1) >= 17'(tdata3_all[LB +: CNT_WIDTH]));
`else
        assign w_cnt_ok[gi] = 1'b1;
`endif
    end

    // Group evaluation: a group matches at its end index only if every member matched
    always_comb begin
        w_grp = '0;
        w_run = 1'b1;
        for (int i = 0; i < int'(NUM_TRIG); i++) begin
            w_run    = w_run & w_q[i];
            w_grp[i] = w_run & ~w_chain[i];
            if (!w_chain[i]) begin
                w_run = 1'b1;
            end
        end
    end

    assign w_fire = w_grp & w_cnt_ok & ~tdata_wr;

    // Arbitration: action 1 beats action 0; within a class the lowest index wins
    always_comb begin
        w_bp  = 1'b0;
        w_bpe = 1'b0;
        w_id  = '0;
        for (int i = int'(NUM_TRIG) - 1; i >= 0; i--) begin
            if (w_fire[i] && w_act0[i]) begin
                w_bpe = 1'b1;
                w_id  = 3'(i);
            end
        end
        for (int i = int'(NUM_TRIG) - 1; i >= 0; i--) begin
            if (w_fire[i] && w_act1[i]) begin
                w_bp = 1'b1;
                w_id = 3'(i);
            end
        end
        if (w_bp) begin
            w_bpe = 1'b0;
        end
    end

    // Registered requests and sticky hit flags (set beats clear)
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            breakpoint     <= 1'b0;
            breakpoint_exp <= 1'b0;
            fire_id        <= '0;
            trig_hit       <= '0;
        end else begin
            breakpoint     <= w_bp;
            breakpoint_exp <= w_bpe;
            fire_id        <= w_id;
            trig_hit       <= (trig_hit & ~(hit_clr | tdata_wr)) | w_grp;
        end
    end

`ifdef TRIG_HIT_COUNT_EN
    // Hit counters: cleared on tdata write or on fire, otherwise bumped per group match
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 0; i < int'(NUM_TRIG); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_TRIG); i++) begin
                if (tdata_wr[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_grp[i]) begin
                    r_cnt[i] <= w_cnt_ok[i] ? '0 : r_cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
